// File: rtl/bus_arb_pkg.sv
// Shared types and field widths for the two-master bus arbiter.
package bus_arb_pkg;

  localparam int unsigned WR_WIDTH_W = 3;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GNT0,
    ARB_GNT1
  } arb_state_t;

endpackage

// File: rtl/arb_watchdog.sv
// Saturating grant-age counter; o_expired flags the last cycle a grant may stay open.
module arb_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_enable && (count_q != CW'(TIMEOUT))) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Count is 0 in the first grant cycle, so TIMEOUT-1 marks the TIMEOUT-th cycle.
  assign o_expired = (count_q >= CW'(TIMEOUT - 1));

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter in front of the memmap CPU port; grant held
// until handshake, abandoned request or watchdog release.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_WIDTH-1:0] i_m0_addr,
  input  logic [DATA_WIDTH-1:0] i_m0_data,
  input  logic                  i_m0_wr_valid,
  output logic                  o_m0_wr_ready,
  input  logic [WR_WIDTH_W-1:0] i_m0_wr_width,
  output logic [DATA_WIDTH-1:0] o_m0_data,
  output logic                  o_m0_rd_valid,
  input  logic                  i_m0_rd_ready,
  input  logic [ADDR_WIDTH-1:0] i_m1_addr,
  input  logic [DATA_WIDTH-1:0] i_m1_data,
  input  logic                  i_m1_wr_valid,
  output logic                  o_m1_wr_ready,
  input  logic [WR_WIDTH_W-1:0] i_m1_wr_width,
  output logic [DATA_WIDTH-1:0] o_m1_data,
  output logic                  o_m1_rd_valid,
  input  logic                  i_m1_rd_ready,
  output logic [ADDR_WIDTH-1:0] o_s_addr,
  output logic [DATA_WIDTH-1:0] o_s_data,
  output logic                  o_s_wr_valid,
  input  logic                  i_s_wr_ready,
  output logic [WR_WIDTH_W-1:0] o_s_wr_width,
  input  logic [DATA_WIDTH-1:0] i_s_data,
  input  logic                  i_s_rd_valid,
  output logic                  o_s_rd_ready,
  output logic [1:0]            o_grant,
  output logic                  o_timeout
);

  arb_state_t state_q, state_d;
  logic       last_q, last_d;
  logic       timeout_q, timeout_d;
  logic       req0, req1, gnt_req, done, expired;

  assign req0 = i_m0_wr_valid | i_m0_rd_ready;
  assign req1 = i_m1_wr_valid | i_m1_rd_ready;
  assign done = (o_s_wr_valid & i_s_wr_ready) | (o_s_rd_ready & i_s_rd_valid);
  assign gnt_req = (state_q == ARB_GNT0) ? req0 : req1;

  arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (state_q == ARB_IDLE),
    .i_enable (state_q != ARB_IDLE),
    .o_expired(expired)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    timeout_d = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        // last only moves on a tie, so a lone requester never shifts priority.
        if (req0 && req1) begin
          state_d = last_q ? ARB_GNT0 : ARB_GNT1;
          last_d  = ~last_q;
        end else if (req0) begin
          state_d = ARB_GNT0;
        end else if (req1) begin
          state_d = ARB_GNT1;
        end
      end
      ARB_GNT0, ARB_GNT1: begin
        if (done || !gnt_req) begin
          state_d = ARB_IDLE;
        end else if (expired) begin
          state_d   = ARB_IDLE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ARB_IDLE;
      last_q    <= 1'b1;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    o_s_addr      = '0;
    o_s_data      = '0;
    o_s_wr_valid  = 1'b0;
    o_s_wr_width  = '0;
    o_s_rd_ready  = 1'b0;
    o_m0_wr_ready = 1'b0;
    o_m0_data     = '0;
    o_m0_rd_valid = 1'b0;
    o_m1_wr_ready = 1'b0;
    o_m1_data     = '0;
    o_m1_rd_valid = 1'b0;
    case (state_q)
      ARB_GNT0: begin
        o_s_addr      = i_m0_addr;
        o_s_data      = i_m0_data;
        o_s_wr_valid  = i_m0_wr_valid;
        o_s_wr_width  = i_m0_wr_width;
        o_s_rd_ready  = i_m0_rd_ready;
        o_m0_wr_ready = i_s_wr_ready;
        o_m0_data     = i_s_data;
        o_m0_rd_valid = i_s_rd_valid;
      end
      ARB_GNT1: begin
        o_s_addr      = i_m1_addr;
        o_s_data      = i_m1_data;
        o_s_wr_valid  = i_m1_wr_valid;
        o_s_wr_width  = i_m1_wr_width;
        o_s_rd_ready  = i_m1_rd_ready;
        o_m1_wr_ready = i_s_wr_ready;
        o_m1_data     = i_s_data;
        o_m1_rd_valid = i_s_rd_valid;
      end
      default: ;
    endcase
  end

  assign o_grant   = {state_q == ARB_GNT1, state_q == ARB_GNT0};
  assign o_timeout = timeout_q;

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Two-master, one-slave arbiter in front of the memmap CPU port. It shares the single address/data bus, with its valid/ready write and read channels, between the core (master 0) and a secondary requester (master 1, e.g. a UART boot loader or DMA).
- Round-robin fairness.
- The grant is held until the granted transaction's handshake completes.
- A watchdog releases a grant that is stuck.
- Sits between core/loader and memmap; the slave side connects unchanged to memmap's i_cpu_* / o_* ports.

Parameters:
DATA_WIDTH, 32, width of data buses (matches `DATA_WIDTH from common.svh)
ADDR_WIDTH, 32, width of address buses
TIMEOUT, 255, cycles a grant may stay open without a completed handshake before forced release; minimum 2

Ports:
i_clk  in  1  clock
i_rst  in  1  reset; synchronous, active-high
i_mN_addr  in  ADDR_WIDTH  master N address (N = 0, 1)
i_mN_data  in  DATA_WIDTH  master N write data
i_mN_wr_valid  in  1  master N write request
o_mN_wr_ready  out  1  write accepted for master N
i_mN_wr_width  in  3  master N write width code
o_mN_data  out  DATA_WIDTH  read data to master N
o_mN_rd_valid  out  1  read data valid to master N
i_mN_rd_ready  in  1  master N read request
o_s_addr  out  ADDR_WIDTH  slave address
o_s_data  out  DATA_WIDTH  slave write data
o_s_wr_valid  out  1  slave write request
i_s_wr_ready  in  1  slave write accept
o_s_wr_width  out  3  slave write width
i_s_data  in  DATA_WIDTH  slave read data
i_s_rd_valid  in  1  slave read valid
o_s_rd_ready  out  1  slave read request
o_grant  out  2  one-hot current grant ({m1,m0}); 00 when idle
o_timeout  out  1  one-cycle pulse on watchdog release

Behaviour:
- Request definition: req_N = i_mN_wr_valid | i_mN_rd_ready.
- Completion of the granted transaction: done = (o_s_wr_valid & i_s_wr_ready) | (o_s_rd_ready & i_s_rd_valid), sampled at posedge.
- FSM states: IDLE, GNT0, GNT1. Registered state; all routing is combinational from state.
- IDLE, no request: stay in IDLE.
- IDLE, only req_N: go to GNTN next cycle.
- IDLE, both requesting: grant the master not equal to last; set last to the granted master.
- GNTN, done: go to IDLE. This gives one bubble cycle between transactions, so a new request is granted no earlier than 2 cycles after the previous completion.
- GNTN, req_N dropped without done: go to IDLE (abandoned request).
- GNTN, watchdog reaches TIMEOUT: go to IDLE and pulse o_timeout for 1 cycle.
- Watchdog counter: cleared on entry to any GNT state, incremented each GNT cycle, saturating.
- Routing in GNTN: slave outputs = master N inputs. o_mN_wr_ready = i_s_wr_ready; o_mN_data = i_s_data; o_mN_rd_valid = i_s_rd_valid.
- Non-granted master: o_*_wr_ready = 0, o_*_rd_valid = 0, o_*_data = 0.
- In IDLE: all slave outputs are 0 and all master ready/valid outputs are 0. Nothing reaches memmap without a grant.
- Master asserting wr and rd together: both are forwarded; the first handshake ends the grant. Masters must not do this; the arbiter does not split it.
- Grant latency: a request in IDLE sees a slave-side request 1 cycle later (registered grant). After that, latency is whatever memmap provides.
- Reset values: state = IDLE, last = 1 (so M0 wins the first tie), counter = 0, o_grant = 00, o_timeout = 0. All outputs are 0 the cycle after reset is asserted.
- Reset mid-transaction: the grant is dropped immediately on the next edge. The slave sees its request removed; memmap is reset by the same i_rst.
- A master changing addr/data while granted is forwarded unchanged. Masters must hold them stable until handshake.

Decomposition:
- Package bus_arb_pkg holds:
  - typedef enum logic [1:0] {ARB_IDLE, ARB_GNT0, ARB_GNT1} arb_state_t
  - the shared localparam for the wr_width field width (3)
- One sub-module: arb_watchdog. It contains the saturating counter with clear/enable inputs and the expired output, parameterised by TIMEOUT.
- Mux/FSM stays in bus_arbiter.

Test Plan:
- Only M0 writes addr 0x0000FFF0, data 0x5A; slave asserts ready 2 cycles after request -> o_grant = 01 one cycle after request; o_m0_wr_ready pulses exactly once; M1 outputs stay 0; o_grant returns to 00 the cycle after the handshake.
- M0 and M1 both request reads in the same cycle after reset -> M0 granted first (data 0x11 returned to M0 only), then M1 (0x22). Repeat with both requesting -> M1 first this time (round-robin).
- M1 holds rd_ready continuously while M0 issues 4 back-to-back writes -> grants alternate M0, M1, M0, M1 …; neither master waits more than one foreign transaction.
- TIMEOUT = 8, M0 reads, slave never asserts rd_valid -> grant released after 8 GNT cycles; o_timeout is high for exactly 1 cycle; a pending M1 request is granted 1 cycle later.
- M0 granted write, i_rst asserted for 1 cycle before ready -> next edge: o_grant = 00, o_s_wr_valid = 0, o_timeout = 0. After reset, a simultaneous M0/M1 request grants M0.
- M0 drops wr_valid while granted with no handshake -> back to IDLE next edge; no o_timeout pulse.
